// File: rtl/shift_amount_unit_if.sv
//------------------------------------------------------------------------------
// Module      : shift_amount_unit_if
// Description : Request/response bundle between the control unit and the
//               iterative shift unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface shift_amount_unit_if #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
);
    logic             start;
    logic [1:0]       mode;
    logic [1:0]       amt_sel;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] reg_b;
    logic [AMT_W-1:0] shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             amt_err;

    modport master (
        output start, mode, amt_sel, data_in, reg_b, shamt,
        input  busy, done, result, amt_err
    );

    modport slave (
        input  start, mode, amt_sel, data_in, reg_b, shamt,
        output busy, done, result, amt_err
    );
endinterface

`default_nettype wire

// File: rtl/shift_amount_unit.sv
//------------------------------------------------------------------------------
// Module      : shift_amount_unit
// Description : Multi-cycle SLL/SRL/SRA/ROR unit with shift-amount source
//               selection, shifting up to STEP bits per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module shift_amount_unit #(
    parameter int WIDTH     = 32,
    parameter int AMT_W     = 5,
    parameter int STEP      = 1,
    parameter int CONST_AMT = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    shift_amount_unit_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [1:0] c_MODE_SLL = 2'b00;
    localparam logic [1:0] c_MODE_SRL = 2'b01;
    localparam logic [1:0] c_MODE_SRA = 2'b10;
    localparam logic [1:0] c_MODE_ROR = 2'b11;

    localparam logic [1:0] c_SEL_REGB  = 2'b00;
    localparam logic [1:0] c_SEL_SHAMT = 2'b01;
    localparam logic [1:0] c_SEL_CONST = 2'b10;

    // Step and width need one extra bit: STEP may equal WIDTH.
    localparam logic [AMT_W:0]   c_STEP  = (AMT_W+1)'(STEP);
    localparam logic [AMT_W:0]   c_WIDTH = (AMT_W+1)'(WIDTH);
    localparam logic [AMT_W-1:0] c_CONST = AMT_W'(CONST_AMT);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [WIDTH-1:0] r_result;
    logic [AMT_W-1:0] r_cnt;
    logic [1:0]       r_mode;
    logic             r_sign;
    logic             r_err;

    logic             w_accept;
    logic [AMT_W-1:0] w_amt;
    logic             w_amt_invalid;
    logic [AMT_W:0]   w_cnt_ext;
    logic [AMT_W:0]   w_k;
    logic [AMT_W:0]   w_k_inv;
    logic [AMT_W-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_fill;
    logic [WIDTH-1:0] w_shifted;
    logic             w_unused_regb;

    assign w_unused_regb = ^bus.reg_b[WIDTH-1:AMT_W];

    // A new request is taken in IDLE and also in DONE, so operations can chain.
    assign w_accept = bus.start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));

    always_comb begin
        w_amt         = '0;
        w_amt_invalid = 1'b0;
        case (bus.amt_sel)
            c_SEL_REGB:  w_amt = bus.reg_b[AMT_W-1:0];
            c_SEL_SHAMT: w_amt = bus.shamt;
            c_SEL_CONST: w_amt = c_CONST;
            default: begin
                w_amt         = '0;
                w_amt_invalid = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_cnt_ext  = {1'b0, r_cnt};
        w_k        = (w_cnt_ext < c_STEP) ? w_cnt_ext : c_STEP;
        w_k_inv    = c_WIDTH - w_k;
        w_cnt_next = r_cnt - w_k[AMT_W-1:0];
    end

    // SRA fill comes from the operand's original MSB, not the current result.
    always_comb begin
        w_fill    = ~({WIDTH{1'b1}} >> w_k);
        w_shifted = r_result;
        case (r_mode)
            c_MODE_SLL: w_shifted = r_result << w_k;
            c_MODE_SRL: w_shifted = r_result >> w_k;
            c_MODE_SRA: w_shifted = (r_result >> w_k) | (r_sign ? w_fill : '0);
            c_MODE_ROR: w_shifted = (r_result >> w_k) | (r_result << w_k_inv);
            default:    w_shifted = r_result;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_amt == '0) ? c_ST_DONE : c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (w_cnt_next == '0) begin
                    w_next_state = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                if (w_accept) begin
                    w_next_state = (w_amt == '0) ? c_ST_DONE : c_ST_SHIFT;
                end else begin
                    w_next_state = c_ST_IDLE;
                end
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_cnt    <= '0;
            r_mode   <= c_MODE_SLL;
            r_sign   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_result <= bus.data_in;
            r_cnt    <= w_amt;
            r_mode   <= bus.mode;
            r_sign   <= bus.data_in[WIDTH-1];
            r_err    <= w_amt_invalid;
        end else if (r_state == c_ST_SHIFT) begin
            r_result <= w_shifted;
            r_cnt    <= w_cnt_next;
        end
    end

    assign bus.busy    = (r_state == c_ST_SHIFT);
    assign bus.done    = (r_state == c_ST_DONE);
    assign bus.amt_err = (r_state == c_ST_DONE) && r_err;
    assign bus.result  = r_result;

endmodule

`default_nettype wire

// File: tb/tb_shift_amount_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_shift_amount_unit
// Description : Directed-vector bench for shift_amount_unit at STEP=1 and STEP=4.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_amount_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start1;
    logic        start4;
    logic [1:0]  mode;
    logic [1:0]  amt_sel;
    logic [31:0] data_in;
    logic [31:0] reg_b;
    logic [4:0]  shamt;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    shift_amount_unit_if #(.WIDTH(32), .AMT_W(5)) b1 ();
    shift_amount_unit_if #(.WIDTH(32), .AMT_W(5)) b4 ();

    assign b1.start   = start1;
    assign b1.mode    = mode;
    assign b1.amt_sel = amt_sel;
    assign b1.data_in = data_in;
    assign b1.reg_b   = reg_b;
    assign b1.shamt   = shamt;
    assign b4.start   = start4;
    assign b4.mode    = mode;
    assign b4.amt_sel = amt_sel;
    assign b4.data_in = data_in;
    assign b4.reg_b   = reg_b;
    assign b4.shamt   = shamt;

    shift_amount_unit #(.WIDTH(32), .AMT_W(5), .STEP(1), .CONST_AMT(16)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1.slave)
    );

    shift_amount_unit #(.WIDTH(32), .AMT_W(5), .STEP(4), .CONST_AMT(16)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (b4.slave)
    );

    function automatic logic get_busy(input bit s4);
        return s4 ? b4.busy : b1.busy;
    endfunction
    function automatic logic get_done(input bit s4);
        return s4 ? b4.done : b1.done;
    endfunction
    function automatic logic get_err(input bit s4);
        return s4 ? b4.amt_err : b1.amt_err;
    endfunction
    function automatic logic [31:0] get_result(input bit s4);
        return s4 ? b4.result : b1.result;
    endfunction

    // Called at a falling edge; the next rising edge is the accept edge.
    task automatic issue(input bit s4, input logic [1:0] m, input logic [1:0] sel,
                         input logic [31:0] d, input logic [31:0] rb, input logic [4:0] sh);
        mode    = m;
        amt_sel = sel;
        data_in = d;
        reg_b   = rb;
        shamt   = sh;
        if (s4) start4 = 1'b1;
        else    start1 = 1'b1;
    endtask

    // ncyc is the cycle number (after the accept edge) in which done was seen; -1 on timeout.
    task automatic wait_done(input bit s4, output int ncyc, output int nbusy,
                             output logic [31:0] res, output logic err, output bit overlap);
        ncyc    = 0;
        nbusy   = 0;
        res     = '0;
        err     = 1'b0;
        overlap = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            start4 = 1'b0;
            ncyc++;
            if (get_busy(s4)) nbusy++;
            if (get_busy(s4) && get_done(s4)) overlap = 1'b1;
            if (get_done(s4)) begin
                res = get_result(s4);
                err = get_err(s4);
                return;
            end
        end
        ncyc = -1;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        start1  = 1'b0;
        start4  = 1'b0;
        mode    = 2'b00;
        amt_sel = 2'b00;
        data_in = '0;
        reg_b   = '0;
        shamt   = '0;
        repeat (3) @(negedge clk);
        vectors++; if ({b1.busy, b1.done, b1.amt_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags1: got %b expected 000", {b1.busy, b1.done, b1.amt_err}); end
        vectors++; if (b1.result !== 32'h0) begin miscompares++; $display("FAIL reset_result1: got %h expected 00000000", b1.result); end
        vectors++; if ({b4.busy, b4.done, b4.amt_err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags4: got %b expected 000", {b4.busy, b4.done, b4.amt_err}); end
        vectors++; if (b4.result !== 32'h0) begin miscompares++; $display("FAIL reset_result4: got %h expected 00000000", b4.result); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sll_regb();
        int n, nb; logic [31:0] r; logic e; bit ov;
        issue(1'b0, 2'b00, 2'b00, 32'h0000_00F1, 32'hFFFF_FFE4, 5'd0);
        wait_done(1'b0, n, nb, r, e, ov);
        vectors++; if (n !== 5)  begin miscompares++; $display("FAIL sll_done_cycle: got %0d expected 5", n); end
        vectors++; if (nb !== 4) begin miscompares++; $display("FAIL sll_busy_cycles: got %0d expected 4", nb); end
        vectors++; if (r !== 32'h0000_0F10) begin miscompares++; $display("FAIL sll_result: got %h expected 00000f10", r); end
        vectors++; if (e !== 1'b0 || ov !== 1'b0) begin miscompares++; $display("FAIL sll_err_overlap: got %b%b expected 00", e, ov); end
    endtask

    task automatic test_sra_const();
        int n, nb; logic [31:0] r; logic e; bit ov;
        issue(1'b0, 2'b10, 2'b10, 32'h8000_1234, 32'h0, 5'd3);
        wait_done(1'b0, n, nb, r, e, ov);
        vectors++; if (n !== 17) begin miscompares++; $display("FAIL sra_done_cycle: got %0d expected 17", n); end
        vectors++; if (r !== 32'hFFFF_8000) begin miscompares++; $display("FAIL sra_result: got %h expected ffff8000", r); end
        vectors++; if (ov !== 1'b0) begin miscompares++; $display("FAIL sra_overlap: got %b expected 0", ov); end
    endtask

    task automatic test_step4();
        int n, nb; logic [31:0] r; logic e; bit ov;
        issue(1'b1, 2'b11, 2'b01, 32'h1234_5678, 32'h0, 5'd8);
        wait_done(1'b1, n, nb, r, e, ov);
        vectors++; if (n !== 3 || nb !== 2) begin miscompares++; $display("FAIL ror4_timing: got done=%0d busy=%0d expected done=3 busy=2", n, nb); end
        vectors++; if (r !== 32'h7812_3456) begin miscompares++; $display("FAIL ror4_result: got %h expected 78123456", r); end
        issue(1'b1, 2'b01, 2'b01, 32'hF000_0000, 32'h0, 5'd7);
        wait_done(1'b1, n, nb, r, e, ov);
        vectors++; if (n !== 3 || nb !== 2) begin miscompares++; $display("FAIL srl4_timing: got done=%0d busy=%0d expected done=3 busy=2", n, nb); end
        vectors++; if (r !== 32'h01E0_0000) begin miscompares++; $display("FAIL srl4_result: got %h expected 01e00000", r); end
        issue(1'b1, 2'b10, 2'b00, 32'h8765_4321, 32'h0000_0025, 5'd0);
        wait_done(1'b1, n, nb, r, e, ov);
        vectors++; if (n !== 3 || r !== 32'hFC3B_2A19) begin miscompares++; $display("FAIL sra4_regb: got done=%0d result=%h expected done=3 result=fc3b2a19", n, r); end
    endtask

    task automatic test_zero_invalid();
        int n, nb; logic [31:0] r; logic e; bit ov;
        issue(1'b0, 2'b00, 2'b01, 32'hDEAD_BEEF, 32'h0000_0007, 5'd0);
        wait_done(1'b0, n, nb, r, e, ov);
        vectors++; if (n !== 1 || nb !== 0) begin miscompares++; $display("FAIL zero_timing: got done=%0d busy=%0d expected done=1 busy=0", n, nb); end
        vectors++; if (r !== 32'hDEAD_BEEF || e !== 1'b0) begin miscompares++; $display("FAIL zero_result: got %h err=%b expected deadbeef err=0", r, e); end
        issue(1'b0, 2'b01, 2'b11, 32'hDEAD_BEEF, 32'h0000_0007, 5'd9);
        wait_done(1'b0, n, nb, r, e, ov);
        vectors++; if (n !== 1 || nb !== 0) begin miscompares++; $display("FAIL inval_timing: got done=%0d busy=%0d expected done=1 busy=0", n, nb); end
        vectors++; if (r !== 32'hDEAD_BEEF || e !== 1'b1) begin miscompares++; $display("FAIL inval_result: got %h err=%b expected deadbeef err=1", r, e); end
        @(negedge clk);
        vectors++; if ({b1.done, b1.amt_err, b1.busy} !== 3'b000) begin miscompares++; $display("FAIL inval_idle_flags: got %b expected 000", {b1.done, b1.amt_err, b1.busy}); end
        vectors++; if (b1.result !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL idle_hold: got %h expected deadbeef", b1.result); end
    endtask

    task automatic test_ignore_start();
        int n = 0;
        int nb = 0;
        logic [31:0] r = '0;
        bit seen = 1'b0;
        issue(1'b0, 2'b00, 2'b01, 32'h0000_0001, 32'h0, 5'd10);
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            n++;
            if (b1.busy) nb++;
            if (b1.done) begin
                seen = 1'b1;
                r = b1.result;
            end else if (n == 3) begin
                issue(1'b0, 2'b01, 2'b01, 32'h0000_FFFF, 32'h0, 5'd1);
            end
        end
        vectors++; if (n !== 11 || nb !== 10) begin miscompares++; $display("FAIL ignore_timing: got done=%0d busy=%0d expected done=11 busy=10", n, nb); end
        vectors++; if (r !== 32'h0000_0400) begin miscompares++; $display("FAIL ignore_result: got %h expected 00000400", r); end
        @(negedge clk);
        vectors++; if ({b1.busy, b1.done} !== 2'b00) begin miscompares++; $display("FAIL ignore_not_queued: got %b expected 00", {b1.busy, b1.done}); end
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 2'b00, 2'b01, 32'h0000_00AB, 32'h0, 5'd8);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (c == 3) begin
                vectors++; if (b4.done !== 1'b1 || b4.result !== 32'h0000_AB00) begin miscompares++; $display("FAIL b2b_first: got done=%b result=%h expected done=1 result=0000ab00", b4.done, b4.result); end
                issue(1'b1, 2'b10, 2'b01, 32'h8000_0000, 32'h0, 5'd4);
            end
            if (c == 4) begin
                vectors++; if ({b4.busy, b4.done} !== 2'b10) begin miscompares++; $display("FAIL b2b_no_gap: got busy,done=%b expected 10", {b4.busy, b4.done}); end
            end
            if (c == 5) begin
                vectors++; if (b4.done !== 1'b1 || b4.result !== 32'hF800_0000) begin miscompares++; $display("FAIL b2b_second: got done=%b result=%h expected done=1 result=f8000000", b4.done, b4.result); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, nb; logic [31:0] r; logic e; bit ov;
        issue(1'b0, 2'b00, 2'b01, 32'h0000_0001, 32'h0, 5'd16);
        repeat (3) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        vectors++; if (b1.busy !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre: got busy=%b expected 1", b1.busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if ({b1.busy, b1.done, b1.amt_err} !== 3'b000 || b1.result !== 32'h0) begin miscompares++; $display("FAIL rst_mid: got flags=%b result=%h expected flags=000 result=00000000", {b1.busy, b1.done, b1.amt_err}, b1.result); end
        issue(1'b0, 2'b01, 2'b00, 32'h0000_0080, 32'h0000_0003, 5'd0);
        wait_done(1'b0, n, nb, r, e, ov);
        vectors++; if (n !== 4 || r !== 32'h0000_0010) begin miscompares++; $display("FAIL rst_after: got done=%0d result=%h expected done=4 result=00000010", n, r); end
    endtask

    initial begin
        test_reset();
        test_sll_regb();
        test_sra_const();
        test_step4();
        test_zero_invalid();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/shift_amount_unit.md
Name: shift_amount_unit

Overview:
- Parametrised, multi-cycle shift unit for the datapath. Replaces the combinational shift-amount source mux plus the downstream shifter.
- Selects the shift amount from one of four sources: reg_b low bits, the instruction shamt field, the constant CONST_AMT, or an invalid code. The invalid code is always defined; no latch on unused codes.
- Performs SLL/SRL/SRA/ROR iteratively, STEP bits per cycle, under a start/done handshake driven by the control unit FSM.

Parameters:
- WIDTH, 32, data width in bits.
- AMT_W, 5, shift-amount width; must equal clog2(WIDTH).
- STEP, 1, maximum bits shifted per cycle; power of two, 1..WIDTH.
- CONST_AMT, 16, constant amount selected by amt_sel=2'b10 (lui-style shift).

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request pulse; sampled only when the unit can accept.
- mode, input, 2, 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- amt_sel, input, 2, 00 reg_b[AMT_W-1:0], 01 shamt, 10 CONST_AMT, 11 invalid.
- data_in, input, WIDTH, operand to shift.
- reg_b, input, WIDTH, register B value; only the low AMT_W bits are used.
- shamt, input, AMT_W, instruction shamt field.
- busy, output, 1, high while in SHIFT.
- done, output, 1, one-cycle pulse when result is valid.
- result, output, WIDTH, shifted value.
- amt_err, output, 1, high with done when the accepted request had amt_sel=11.

Behaviour:
- Reset (synchronous, priority over everything, including mid-operation):
  - state=IDLE; result=0; busy=0; done=0; amt_err=0; internal count=0.
- States: IDLE, SHIFT, DONE.
- Accept condition: start=1 while in IDLE or DONE. start while in SHIFT is ignored; it is neither queued nor does it affect the operation in flight.
- On accept:
  - Latch mode and data_in into result.
  - Latch the amount into cnt:
    - amt_sel 00: reg_b[AMT_W-1:0].
    - amt_sel 01: shamt.
    - amt_sel 10: CONST_AMT truncated to AMT_W bits.
    - amt_sel 11: 0, and set the internal err flag.
  - Next state is DONE if the latched amount is 0, otherwise SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, cnt).
  - Shift result by k per the latched mode:
    - SLL: zero fill from the LSB side.
    - SRL: zero fill from the MSB side.
    - SRA: fill with the latched operand's original MSB.
    - ROR: bits leaving the LSB re-enter at the MSB.
  - cnt = cnt - k. When cnt reaches 0, go to DONE.
- Latency: with start accepted at edge 0 and n = ceil(amt/STEP), busy=1 during cycles 1..n and done=1 during cycle n+1. For amt=0, done=1 during cycle 1.
- DONE:
  - done=1 for exactly one cycle; amt_err = err flag.
  - Then go to IDLE, unless start is accepted, which begins the new operation (back-to-back).
- result:
  - Intermediate values are visible during SHIFT and are not valid there.
  - Valid from the DONE cycle; held unchanged in IDLE until the next accept.
- Amounts are always < WIDTH by construction (AMT_W bits), so no over-shift case exists.
- busy and done are never high in the same cycle.

Test Plan:
- STEP=1, SLL, amt_sel=00, reg_b=0xFFFF_FFE4 (low 5 bits = 4), data_in=0x0000_00F1 -> busy cycles 1-4, done in cycle 5, result=0x0000_0F10, amt_err=0.
- STEP=1, SRA, amt_sel=10, data_in=0x8000_1234 -> done in cycle 17, result=0xFFFF_8000.
- STEP=4, ROR, amt_sel=01, shamt=8, data_in=0x1234_5678 -> 2 busy cycles, done in cycle 3, result=0x7812_3456. Also SRL shamt=7 on 0xF000_0000 -> 2 busy cycles, result=0x01E0_0000.
- Zero and invalid amounts: shamt=0 with amt_sel=01, data_in=0xDEAD_BEEF -> busy never high, done in cycle 1, result=0xDEAD_BEEF, amt_err=0. Then amt_sel=11 -> same timing, amt_err=1 with done.
- Handshake: during a 10-cycle SLL, pulse start with different operands -> ignored, original result delivered. Start asserted in the DONE cycle -> new operation begins with no IDLE gap.
- Reset mid-SHIFT (cycle 3 of 16) -> next cycle state IDLE, result=0, busy=0, done=0. A following start behaves normally.
